// File: rtl/if_fsm.sv
// ============================================================================
// if_fsm : instruction fetch sequencer (opcode, operand and pointer reads,
//          addressing-mode resolution and fall-through PC)
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        if_start,
  input  logic [15:0] pc_next,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] if_mem_addr,
  output logic        if_mem_read_en,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  dec_opcode,
  input  logic [3:0]  dec_mode,
  input  logic [7:0]  dec_simple_op,
  input  logic [3:0]  dec_alu_op,
  input  logic [2:0]  dec_store_flag,
  input  logic [1:0]  dec_reg_load_flag,
  input  logic        dec_mem_load_flag,
  output logic        if_ready,
  output logic [15:0] if_addr_in,
  output logic [15:0] if_pc_next,
  output logic [7:0]  simple_op,
  output logic [3:0]  alu_op_in,
  output logic [2:0]  store_flag,
  output logic [1:0]  reg_load_flag,
  output logic        mem_load_flag,
  output logic        immediate_flag
);

  localparam logic [3:0] c_MODE_IMP  = 4'd0;
  localparam logic [3:0] c_MODE_ACC  = 4'd1;
  localparam logic [3:0] c_MODE_IMM  = 4'd2;
  localparam logic [3:0] c_MODE_ZP   = 4'd3;
  localparam logic [3:0] c_MODE_ZPX  = 4'd4;
  localparam logic [3:0] c_MODE_ZPY  = 4'd5;
  localparam logic [3:0] c_MODE_ABS  = 4'd6;
  localparam logic [3:0] c_MODE_ABSX = 4'd7;
  localparam logic [3:0] c_MODE_ABSY = 4'd8;
  localparam logic [3:0] c_MODE_IND  = 4'd9;
  localparam logic [3:0] c_MODE_INDX = 4'd10;
  localparam logic [3:0] c_MODE_INDY = 4'd11;
  localparam logic [3:0] c_MODE_REL  = 4'd12;

  // The read address/strobe are registered on the IDLE (start) and TAKE edges,
  // so "issue" is an action of those edges rather than a resident state.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_TAKE = 3'd2,
    S_DONE = 3'd3
  } state_t;

  typedef enum logic [2:0] {
    T_OPC = 3'd0,
    T_LO  = 3'd1,
    T_HI  = 3'd2,
    T_PLO = 3'd3,
    T_PHI = 3'd4
  } step_t;

  state_t      r_state;
  step_t       r_step;
  logic [15:0] r_base;
  logic [7:0]  r_opcode;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic [7:0]  r_plo;
  logic [7:0]  r_phi;

  logic        w_take_opc;
  logic [3:0]  w_mode;
  logic [1:0]  w_nops;
  logic [7:0]  w_data_x;
  logic [7:0]  w_lo_1;
  logic [7:0]  w_lo_x;
  logic [7:0]  w_lo_x1;
  logic [7:0]  w_lo_y;
  logic        w_more;
  logic [15:0] w_next_addr;
  step_t       w_next_step;
  logic [15:0] w_pc_nx;
  logic [15:0] w_abs;
  logic [15:0] w_ptr;
  logic [15:0] w_result;

  // While the opcode byte is being taken, the ROM is fed straight from the bus
  // so the operand read can be chosen on the same edge as the capture.
  assign w_take_opc = (r_state == S_TAKE) && (r_step == T_OPC);
  assign dec_opcode = w_take_opc ? mem_data_in : r_opcode;

  assign w_mode   = (dec_mode > c_MODE_REL) ? c_MODE_IMP : dec_mode;
  assign w_data_x = mem_data_in + x;
  assign w_lo_1   = r_lo + 8'd1;
  assign w_lo_x   = r_lo + x;
  assign w_lo_x1  = w_lo_x + 8'd1;
  assign w_lo_y   = r_lo + y;
  assign w_pc_nx  = r_base + 16'd1 + {14'd0, w_nops};
  assign w_abs    = {r_hi, r_lo};
  assign w_ptr    = {r_phi, r_plo};

  always_comb begin
    w_nops = 2'd0;
    case (w_mode)
      c_MODE_IMM, c_MODE_ZP, c_MODE_ZPX, c_MODE_ZPY,
      c_MODE_INDX, c_MODE_INDY, c_MODE_REL:          w_nops = 2'd1;
      c_MODE_ABS, c_MODE_ABSX, c_MODE_ABSY, c_MODE_IND: w_nops = 2'd2;
      default:                                        w_nops = 2'd0;
    endcase
  end

  always_comb begin
    w_more      = 1'b0;
    w_next_addr = 16'h0000;
    w_next_step = T_OPC;
    case (r_step)
      T_OPC: begin
        if (w_nops != 2'd0) begin
          w_more      = 1'b1;
          w_next_addr = r_base + 16'd1;
          w_next_step = T_LO;
        end
      end
      T_LO: begin
        if (w_nops == 2'd2) begin
          w_more      = 1'b1;
          w_next_addr = r_base + 16'd2;
          w_next_step = T_HI;
        end else if (w_mode == c_MODE_INDX) begin
          w_more      = 1'b1;
          w_next_addr = {8'h00, w_data_x};
          w_next_step = T_PLO;
        end else if (w_mode == c_MODE_INDY) begin
          w_more      = 1'b1;
          w_next_addr = {8'h00, mem_data_in};
          w_next_step = T_PLO;
        end
      end
      T_HI: begin
        if (w_mode == c_MODE_IND) begin
          w_more      = 1'b1;
          w_next_addr = {mem_data_in, r_lo};
          w_next_step = T_PLO;
        end
      end
      T_PLO: begin
        // Pointer high byte never carries into the next page.
        w_more      = 1'b1;
        w_next_step = T_PHI;
        if (w_mode == c_MODE_IND)
          w_next_addr = {r_hi, w_lo_1};
        else if (w_mode == c_MODE_INDX)
          w_next_addr = {8'h00, w_lo_x1};
        else
          w_next_addr = {8'h00, w_lo_1};
      end
      default: w_more = 1'b0;
    endcase
  end

  always_comb begin
    w_result = 16'h0000;
    case (w_mode)
      c_MODE_IMM, c_MODE_ZP:    w_result = {8'h00, r_lo};
      c_MODE_ZPX:               w_result = {8'h00, w_lo_x};
      c_MODE_ZPY:               w_result = {8'h00, w_lo_y};
      c_MODE_ABS:               w_result = w_abs;
      c_MODE_ABSX:              w_result = w_abs + {8'h00, x};
      c_MODE_ABSY:              w_result = w_abs + {8'h00, y};
      c_MODE_IND, c_MODE_INDX:  w_result = w_ptr;
      c_MODE_INDY:              w_result = w_ptr + {8'h00, y};
      c_MODE_REL:               w_result = w_pc_nx + {{8{r_lo[7]}}, r_lo};
      default:                  w_result = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_step         <= T_OPC;
      r_base         <= 16'h0000;
      r_opcode       <= 8'h00;
      r_lo           <= 8'h00;
      r_hi           <= 8'h00;
      r_plo          <= 8'h00;
      r_phi          <= 8'h00;
      if_mem_addr    <= 16'h0000;
      if_mem_read_en <= 1'b0;
      if_ready       <= 1'b0;
      if_addr_in     <= 16'h0000;
      if_pc_next     <= 16'h0000;
      simple_op      <= 8'h00;
      alu_op_in      <= 4'h0;
      store_flag     <= 3'h0;
      reg_load_flag  <= 2'h0;
      mem_load_flag  <= 1'b0;
      immediate_flag <= 1'b0;
    end else if (!halt) begin
      case (r_state)
        S_IDLE: begin
          if (if_start) begin
            if_ready       <= 1'b0;
            r_base         <= pc_next;
            if_mem_addr    <= pc_next;
            if_mem_read_en <= 1'b1;
            r_step         <= T_OPC;
            r_state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if_mem_read_en <= 1'b0;
          r_state        <= S_TAKE;
        end
        S_TAKE: begin
          case (r_step)
            T_OPC:   r_opcode <= mem_data_in;
            T_LO:    r_lo     <= mem_data_in;
            T_HI:    r_hi     <= mem_data_in;
            T_PLO:   r_plo    <= mem_data_in;
            T_PHI:   r_phi    <= mem_data_in;
            default: r_phi    <= r_phi;
          endcase
          if (w_more) begin
            if_mem_addr    <= w_next_addr;
            if_mem_read_en <= 1'b1;
            r_step         <= w_next_step;
            r_state        <= S_WAIT;
          end else begin
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          if_addr_in     <= w_result;
          if_pc_next     <= w_pc_nx;
          simple_op      <= dec_simple_op;
          alu_op_in      <= dec_alu_op;
          store_flag     <= dec_store_flag;
          reg_load_flag  <= dec_reg_load_flag;
          mem_load_flag  <= dec_mem_load_flag;
          immediate_flag <= (w_mode == c_MODE_IMM);
          if_ready       <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
